bumpy_frame_sequencer: RTL and testbench
========================================

// Module: bumpy_frame_sequencer
// PURPOSE
//  Per-frame command scheduler in front of the Bumpy movement datapath.
//  - Between startOfFrame pulses, it accumulates the asynchronous collision sources and the key events.
//  - At each frame start, it arbitrates them by fixed priority.
//  - It issues them one at a time over a valid/ready command port that the movement logic consumes.
//  - Every frame ends with exactly one MOVE command.
// PARAMETERS
//  KEY_SYNC_STAGES     2  synchronizer depth for NX_Left/NX_Right/NJump
//  JUMP_BUFFER_FRAMES  4  frames a jump press stays pending before it is dropped
//  STAT_W              8  width of frame/overrun counters (saturating)
// PORTS
//  clk                      in   1       system clock
//  reset                    in   1       synchronous, active-high
//  startOfFrame             in   1       1-cycle pulse per frame
//  NX_Left/NX_Right/NJump   in   1 each  keys, active-low, asynchronous
//  collision_wall           in   1       wall hit, single-cycle pulses allowed
//  collision_platform       in   1       platform hit
//  collision_transplatform  in   1       transparent-platform hit
//  HitEdgeCode              in   4       {Left,Top,Right,Bottom}; valid with collision_wall
//  cmd_ready                in   1       movement logic accepts cmd
//  cmd_valid                out  1       command available
//  cmd_op                   out  3       seq_op_t: NONE/WALL/PLAT/TRANS/MOVE
//  cmd_edge                 out  4       OR of HitEdgeCode over frame (WALL only, else 0)
//  cmd_jump                 out  1       jump request (PLAT/TRANS only)
//  cmd_dir                  out  2       2'b10 left, 2'b01 right, 2'b00 none
//  overrun                  out  1       sticky: frame started before sequence done
//  frame_cnt                out  STAT_W  frames seen (stats)
//  overrun_cnt              out  STAT_W  overruns seen (stats)
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; accumulators, jump buffer, pending set cleared. Takes effect mid-ISSUE.
//  - Accumulate: sticky OR of each collision input and of HitEdgeCode (gated by collision_wall) between SOFs.
//    - An input coincident with SOF goes to the NEXT frame's accumulator.
//  - Keys: synchronized, then combined into direction.
//    - Both pressed -> left (left has priority).
//    - cmd_dir is the sampled key level at SOF.
//  - Jump buffer:
//    - A falling edge of synchronized NJump sets jump_pend and loads cnt=JUMP_BUFFER_FRAMES.
//    - Each SOF decrements cnt; jump_pend clears when cnt reaches 0.
//    - jump_pend is consumed on handshake of PLAT/TRANS with cmd_jump=1.
//    - New press in the same cycle as consumption: press wins (pend stays 1, cnt reloaded).
//  - SOF snapshot: pending set = {wall,plat,trans} accumulators plus MOVE (always set); accumulators then clear.
//  - FSM IDLE->ARB->ISSUE->(ARB|IDLE):
//    - SOF in IDLE: snapshot; next state ARB.
//    - ARB: pick highest pending bit (WALL>PLAT>TRANS>MOVE); load cmd regs; next state ISSUE.
//    - ISSUE: cmd_valid=1; cmd regs stable until cmd_valid&&cmd_ready. On handshake, clear that bit;
//      next state ARB if bits remain, else IDLE.
//    - Latency: SOF at cycle t -> first cmd_valid at t+2. Each command after it takes >=2 cycles (ARB bubble).
//  - Overrun: SOF while state!=IDLE.
//    - Drop remaining pending; set overrun; overrun_cnt++.
//    - Take new snapshot; next state ARB (cmd_valid drops for the ARB cycle).
//  - Counters saturate at 2^STAT_W-1; no wrap.
// CONFIGURATION
//  BUMPY_SEQ_STATS_EN defined:  frame_cnt/overrun_cnt counters are built; overrun stays sticky until reset.
//  BUMPY_SEQ_STATS_EN undefined: frame_cnt and overrun_cnt tied to 0; overrun flag still functional.
// STRUCTURE
//  - Package bumpy_seq_pkg:
//    - seq_op_t enum (NONE=0, WALL=1, PLAT=2, TRANS=3, MOVE=4)
//    - seq_state_t enum (IDLE, ARB, ISSUE)
//    - DIR_LEFT/DIR_RIGHT/DIR_NONE constants
//    - EDGE_* bit-index constants
//  - Sub-module key_sync_edge: KEY_SYNC_STAGES synchronizer plus falling-edge pulse.
//    Instantiated once per key.
// TESTING
//  - Reset mid-ISSUE (cmd_ready=0), reset held 3 cycles -> cmd_valid=0 and state IDLE on the next cycle;
//    the next SOF issues MOVE only.
//  - Wall(HitEdgeCode=4'b1000) + platform in frame, cmd_ready=1 -> WALL(edge 1000) @t+2, PLAT @t+4, MOVE @t+6.
//  - Wall at t+2, cmd_ready=0 for 5 cycles -> cmd_op/cmd_edge stable; handshake on cycle 6; PLAT follows 2 cycles later.
//  - NJump press in frame 0, platform in frame 3 -> PLAT with cmd_jump=1.
//    Same press with platform in frame 5 -> cmd_jump=0.
//  - cmd_ready=0 across next SOF -> overrun=1, overrun_cnt=1, new sequence restarts at ARB.
//  - NX_Left=NX_Right=0 -> MOVE cmd_dir=2'b10. Collision pulse on the SOF cycle -> appears the following frame.

Source files
------------

// File: rtl/bumpy_seq_pkg.sv
// Shared types and constants for the Bumpy frame sequencer.
// Statistics counters are built only when BUMPY_SEQ_STATS_EN is defined.
package bumpy_seq_pkg;

  typedef enum logic [2:0] {
    OpNone  = 3'd0,
    OpWall  = 3'd1,
    OpPlat  = 3'd2,
    OpTrans = 3'd3,
    OpMove  = 3'd4
  } seq_op_t;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StArb   = 2'd1,
    StIssue = 2'd2
  } seq_state_t;

  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_NONE  = 2'b00;

  localparam int unsigned EDGE_LEFT   = 3;
  localparam int unsigned EDGE_TOP    = 2;
  localparam int unsigned EDGE_RIGHT  = 1;
  localparam int unsigned EDGE_BOTTOM = 0;

  // Bit positions in the per-frame pending set; lower index wins arbitration.
  localparam int unsigned PEND_WALL  = 0;
  localparam int unsigned PEND_PLAT  = 1;
  localparam int unsigned PEND_TRANS = 2;
  localparam int unsigned PEND_MOVE  = 3;

  function automatic logic [1:0] dir_from_keys(input logic left, input logic right);
    if (left) return DIR_LEFT;
    if (right) return DIR_RIGHT;
    return DIR_NONE;
  endfunction

  function automatic logic [3:0] op_pend_mask(input seq_op_t op);
    logic [3:0] mask;
    mask = '0;
    case (op)
      OpWall:  mask[PEND_WALL]  = 1'b1;
      OpPlat:  mask[PEND_PLAT]  = 1'b1;
      OpTrans: mask[PEND_TRANS] = 1'b1;
      OpMove:  mask[PEND_MOVE]  = 1'b1;
      default: mask = '0;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/key_sync_edge.sv
// Synchronizer for one active-low asynchronous key plus a one-cycle pulse on
// the synchronized falling edge (key press).
module key_sync_edge #(
  parameter int unsigned Stages = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic key_ni,
  output logic level_no,
  output logic fall_o
);

  logic [Stages-1:0] sync_q, sync_d;
  logic              last_q, last_d;

  always_comb begin
    sync_d   = (sync_q << 1) | Stages'(key_ni);
    last_d   = sync_q[Stages-1];
    level_no = sync_q[Stages-1];
    fall_o   = last_q & ~sync_q[Stages-1];
  end

  // Reset to the released level so reset release never looks like a press.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q <= '1;
      last_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/bumpy_frame_sequencer.sv
// Per-frame command scheduler: accumulates collisions/keys, then issues one command at a
// time per frame (ending with MOVE). Define BUMPY_SEQ_STATS_EN to build the stat counters.
module bumpy_frame_sequencer
  import bumpy_seq_pkg::*;
#(
  parameter int unsigned KEY_SYNC_STAGES    = 2,
  parameter int unsigned JUMP_BUFFER_FRAMES = 4,
  parameter int unsigned STAT_W             = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              startOfFrame,
  input  logic              NX_Left,
  input  logic              NX_Right,
  input  logic              NJump,
  input  logic              collision_wall,
  input  logic              collision_platform,
  input  logic              collision_transplatform,
  input  logic [3:0]        HitEdgeCode,
  input  logic              cmd_ready,
  output logic              cmd_valid,
  output logic [2:0]        cmd_op,
  output logic [3:0]        cmd_edge,
  output logic              cmd_jump,
  output logic [1:0]        cmd_dir,
  output logic              overrun,
  output logic [STAT_W-1:0] frame_cnt,
  output logic [STAT_W-1:0] overrun_cnt
);

  localparam int unsigned JcntW = $clog2(JUMP_BUFFER_FRAMES + 1);

  logic left_n, right_n, jump_fall;
  logic left_fall_unused, right_fall_unused, jump_level_unused;

  key_sync_edge #(.Stages(KEY_SYNC_STAGES)) u_sync_left (
    .clk_i(clk), .reset_i(reset), .key_ni(NX_Left), .level_no(left_n), .fall_o(left_fall_unused)
  );
  key_sync_edge #(.Stages(KEY_SYNC_STAGES)) u_sync_right (
    .clk_i(clk), .reset_i(reset), .key_ni(NX_Right), .level_no(right_n),
    .fall_o(right_fall_unused)
  );
  key_sync_edge #(.Stages(KEY_SYNC_STAGES)) u_sync_jump (
    .clk_i(clk), .reset_i(reset), .key_ni(NJump), .level_no(jump_level_unused),
    .fall_o(jump_fall)
  );

  seq_state_t       state_q, state_d;
  seq_op_t          cmd_op_q, cmd_op_d;
  logic             cmd_valid_q, cmd_valid_d, cmd_jump_q, cmd_jump_d;
  logic [3:0]       cmd_edge_q, cmd_edge_d;
  logic [1:0]       cmd_dir_q, cmd_dir_d, dir_snap_q, dir_snap_d;
  logic             acc_wall_q, acc_wall_d, acc_plat_q, acc_plat_d, acc_trans_q, acc_trans_d;
  logic [3:0]       acc_edge_q, acc_edge_d, edge_snap_q, edge_snap_d, pend_q, pend_d;
  logic             jump_pend_q, jump_pend_d, overrun_q, overrun_d;
  logic [JcntW-1:0] jump_cnt_q, jump_cnt_d;
  logic             hs, overrun_evt;

  assign hs          = cmd_valid_q & cmd_ready;
  assign overrun_evt = startOfFrame && (state_q != StIdle);

  always_comb begin
    state_d     = state_q;
    cmd_valid_d = cmd_valid_q;
    cmd_op_d    = cmd_op_q;
    cmd_edge_d  = cmd_edge_q;
    cmd_jump_d  = cmd_jump_q;
    cmd_dir_d   = cmd_dir_q;
    dir_snap_d  = dir_snap_q;
    edge_snap_d = edge_snap_q;
    pend_d      = pend_q;
    jump_pend_d = jump_pend_q;
    jump_cnt_d  = jump_cnt_q;
    overrun_d   = overrun_q;

    // Inputs coincident with SOF seed the next frame's accumulators.
    if (startOfFrame) begin
      acc_wall_d  = collision_wall;
      acc_plat_d  = collision_platform;
      acc_trans_d = collision_transplatform;
      acc_edge_d  = collision_wall ? HitEdgeCode : 4'b0;
    end else begin
      acc_wall_d  = acc_wall_q | collision_wall;
      acc_plat_d  = acc_plat_q | collision_platform;
      acc_trans_d = acc_trans_q | collision_transplatform;
      acc_edge_d  = acc_edge_q | (collision_wall ? HitEdgeCode : 4'b0);
    end

    if (startOfFrame && jump_pend_q) begin
      jump_cnt_d = jump_cnt_q - JcntW'(1);
      if (jump_cnt_q == JcntW'(1)) jump_pend_d = 1'b0;
    end
    if (hs && cmd_jump_q) jump_pend_d = 1'b0;
    if (jump_fall) begin
      jump_pend_d = 1'b1;
      jump_cnt_d  = JcntW'(JUMP_BUFFER_FRAMES);
    end

    unique case (state_q)
      StIdle: ;
      StArb: begin
        state_d     = StIssue;
        cmd_valid_d = 1'b1;
        cmd_dir_d   = dir_snap_q;
        cmd_edge_d  = 4'b0;
        cmd_jump_d  = 1'b0;
        if (pend_q[PEND_WALL]) begin
          cmd_op_d   = OpWall;
          cmd_edge_d = edge_snap_q;
        end else if (pend_q[PEND_PLAT]) begin
          cmd_op_d   = OpPlat;
          cmd_jump_d = jump_pend_q;
        end else if (pend_q[PEND_TRANS]) begin
          cmd_op_d   = OpTrans;
          cmd_jump_d = jump_pend_q;
        end else begin
          cmd_op_d = OpMove;
        end
      end
      StIssue: begin
        if (hs) begin
          pend_d      = pend_q & ~op_pend_mask(cmd_op_q);
          state_d     = (pend_d != 4'b0) ? StArb : StIdle;
          cmd_valid_d = 1'b0;
          cmd_op_d    = OpNone;
          cmd_edge_d  = 4'b0;
          cmd_jump_d  = 1'b0;
          cmd_dir_d   = DIR_NONE;
        end
      end
      default: state_d = StIdle;
    endcase

    // SOF always restarts the sequence; anything still pending is dropped.
    if (startOfFrame) begin
      if (overrun_evt) overrun_d = 1'b1;
      pend_d      = {1'b1, acc_trans_q, acc_plat_q, acc_wall_q};
      edge_snap_d = acc_edge_q;
      dir_snap_d  = dir_from_keys(~left_n, ~right_n);
      state_d     = StArb;
      cmd_valid_d = 1'b0;
      cmd_op_d    = OpNone;
      cmd_edge_d  = 4'b0;
      cmd_jump_d  = 1'b0;
      cmd_dir_d   = DIR_NONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cmd_valid_q <= 1'b0;
      cmd_op_q    <= OpNone;
      cmd_edge_q  <= 4'b0;
      cmd_jump_q  <= 1'b0;
      cmd_dir_q   <= DIR_NONE;
      dir_snap_q  <= DIR_NONE;
      edge_snap_q <= 4'b0;
      pend_q      <= 4'b0;
      acc_wall_q  <= 1'b0;
      acc_plat_q  <= 1'b0;
      acc_trans_q <= 1'b0;
      acc_edge_q  <= 4'b0;
      jump_pend_q <= 1'b0;
      jump_cnt_q  <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_op_q    <= cmd_op_d;
      cmd_edge_q  <= cmd_edge_d;
      cmd_jump_q  <= cmd_jump_d;
      cmd_dir_q   <= cmd_dir_d;
      dir_snap_q  <= dir_snap_d;
      edge_snap_q <= edge_snap_d;
      pend_q      <= pend_d;
      acc_wall_q  <= acc_wall_d;
      acc_plat_q  <= acc_plat_d;
      acc_trans_q <= acc_trans_d;
      acc_edge_q  <= acc_edge_d;
      jump_pend_q <= jump_pend_d;
      jump_cnt_q  <= jump_cnt_d;
      overrun_q   <= overrun_d;
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_op    = cmd_op_q;
  assign cmd_edge  = cmd_edge_q;
  assign cmd_jump  = cmd_jump_q;
  assign cmd_dir   = cmd_dir_q;
  assign overrun   = overrun_q;

`ifdef BUMPY_SEQ_STATS_EN
  localparam logic [STAT_W-1:0] StatMax = '1;
  logic [STAT_W-1:0] frame_cnt_q, frame_cnt_d, overrun_cnt_q, overrun_cnt_d;

  always_comb begin
    frame_cnt_d   = frame_cnt_q;
    overrun_cnt_d = overrun_cnt_q;
    if (startOfFrame && (frame_cnt_q != StatMax)) frame_cnt_d = frame_cnt_q + 1'b1;
    if (overrun_evt && (overrun_cnt_q != StatMax)) overrun_cnt_d = overrun_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt_q   <= '0;
      overrun_cnt_q <= '0;
    end else begin
      frame_cnt_q   <= frame_cnt_d;
      overrun_cnt_q <= overrun_cnt_d;
    end
  end

  assign frame_cnt   = frame_cnt_q;
  assign overrun_cnt = overrun_cnt_q;
`else
  assign frame_cnt   = '0;
  assign overrun_cnt = '0;
`endif

endmodule

// File: tb/tb_bumpy_frame_sequencer.sv
// Scoreboard bench for bumpy_frame_sequencer: stimulus pushes expected commands,
// a negedge monitor pops and compares them on each cmd handshake.
module tb_bumpy_frame_sequencer;
  import bumpy_seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset, sof, nl, nr, nj, cw, cp, ct, rdy;
  logic [3:0]  hec;
  logic        cmd_valid, cmd_jump, overrun;
  logic [2:0]  cmd_op;
  logic [3:0]  cmd_edge;
  logic [1:0]  cmd_dir;
  logic [7:0]  frame_cnt, overrun_cnt;

  bumpy_frame_sequencer dut (
    .clk(clk), .reset(reset), .startOfFrame(sof), .NX_Left(nl), .NX_Right(nr), .NJump(nj),
    .collision_wall(cw), .collision_platform(cp), .collision_transplatform(ct),
    .HitEdgeCode(hec), .cmd_ready(rdy), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_edge(cmd_edge), .cmd_jump(cmd_jump), .cmd_dir(cmd_dir), .overrun(overrun),
    .frame_cnt(frame_cnt), .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0] op;
    logic [3:0] edg;
    logic       jmp;
    logic [1:0] dir;
    logic       chk_dir;
    int         start;
  } exp_t;

  exp_t q[$];
  int   vecs = 0;
  int   bad = 0;
  int   exp_frames = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vecs++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic void push(input logic [2:0] op, input logic [3:0] e, input logic j,
                               input logic [1:0] d, input int st);
    exp_t x;
    x.op = op; x.edg = e; x.jmp = j; x.dir = d; x.chk_dir = (op == OpMove); x.start = st;
    q.push_back(x);
  endfunction

  function automatic int stat_exp(input int n);
`ifdef BUMPY_SEQ_STATS_EN
    return (n > 255) ? 255 : n;
`else
    return 0;
`endif
  endfunction

  // Monitor: track when each command first shows, check it holds, score on handshake.
  logic       in_cmd = 1'b0;
  logic [2:0] hold_op;
  logic [3:0] hold_edge;
  int         start_cyc;
  exp_t       e;

  always @(negedge clk) begin
    if (reset) begin
      in_cmd = 1'b0;
    end else if (cmd_valid) begin
      if (!in_cmd) begin
        in_cmd = 1'b1; start_cyc = cyc; hold_op = cmd_op; hold_edge = cmd_edge;
      end else begin
        check("stable_op", 32'(cmd_op), 32'(hold_op));
        check("stable_edge", 32'(cmd_edge), 32'(hold_edge));
      end
      if (rdy) begin
        if (q.size() == 0) begin
          vecs++; bad++;
          $display("FAIL unexpected_cmd: got op %0d expected none (cycle %0d)", cmd_op, cyc);
        end else begin
          e = q.pop_front();
          check("op", 32'(cmd_op), 32'(e.op));
          check("edge", 32'(cmd_edge), 32'(e.edg));
          check("jump", 32'(cmd_jump), 32'(e.jmp));
          if (e.chk_dir) check("dir", 32'(cmd_dir), 32'(e.dir));
          if (e.start >= 0) check("issue_cycle", 32'(start_cyc), 32'(e.start));
        end
        in_cmd = 1'b0;
      end
    end else begin
      in_cmd = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_sof(output int t);
    t = cyc; sof = 1'b1;
    tick(1);
    sof = 1'b0; exp_frames++;
  endtask

  int t, t2;
  logic [3:0] e_left, e_top, e_right, e_bottom;

  initial begin
    e_left = 4'b0; e_left[EDGE_LEFT] = 1'b1;
    e_top = 4'b0; e_top[EDGE_TOP] = 1'b1;
    e_right = 4'b0; e_right[EDGE_RIGHT] = 1'b1;
    e_bottom = 4'b0; e_bottom[EDGE_BOTTOM] = 1'b1;
    reset = 1'b1; sof = 1'b0; nl = 1'b1; nr = 1'b1; nj = 1'b1;
    cw = 1'b0; cp = 1'b0; ct = 1'b0; hec = 4'b0; rdy = 1'b1;
    tick(3);
    reset = 1'b0;
    check("rst_valid", 32'(cmd_valid), 0);
    check("rst_op", 32'(cmd_op), 0);
    check("rst_edge", 32'(cmd_edge), 0);
    check("rst_jump", 32'(cmd_jump), 0);
    check("rst_dir", 32'(cmd_dir), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_frame_cnt", 32'(frame_cnt), 0);
    check("rst_overrun_cnt", 32'(overrun_cnt), 0);

    // Wall (left edge) + platform: WALL, PLAT, MOVE at t+2, t+4, t+6.
    cw = 1'b1; hec = e_left; tick(1);
    cw = 1'b0; hec = 4'b1111; cp = 1'b1; tick(1);   // edge code ignored without wall
    cp = 1'b0; hec = 4'b0; tick(2);
    do_sof(t);
    push(OpWall, 4'b1000, 1'b0, DIR_NONE, t + 2);
    push(OpPlat, 4'b0, 1'b0, DIR_NONE, t + 4);
    push(OpMove, 4'b0, 1'b0, DIR_NONE, t + 6);
    tick(10);

    // Edge codes OR across the frame; transparent platform ranks after wall.
    cw = 1'b1; hec = e_top; tick(1);
    hec = e_bottom; tick(1);
    cw = 1'b0; hec = 4'b0; ct = 1'b1; tick(1);
    ct = 1'b0; tick(2);
    do_sof(t);
    push(OpWall, 4'b0101, 1'b0, DIR_NONE, t + 2);
    push(OpTrans, 4'b0, 1'b0, DIR_NONE, t + 4);
    push(OpMove, 4'b0, 1'b0, DIR_NONE, t + 6);
    tick(10);
    check("frame_cnt_2", 32'(frame_cnt), 32'(stat_exp(exp_frames)));

    // Stall: WALL held 5 cycles, handshake at t+7, PLAT at t+9.
    cw = 1'b1; hec = e_right; cp = 1'b1; tick(1);
    cw = 1'b0; hec = 4'b0; cp = 1'b0; tick(2);
    rdy = 1'b0;
    do_sof(t);
    push(OpWall, 4'b0010, 1'b0, DIR_NONE, t + 2);
    push(OpPlat, 4'b0, 1'b0, DIR_NONE, t + 9);
    push(OpMove, 4'b0, 1'b0, DIR_NONE, t + 11);
    tick(3);
    check("stall_valid", 32'(cmd_valid), 1);
    check("stall_op", 32'(cmd_op), 32'(OpWall));
    tick(3);
    rdy = 1'b1;
    tick(10);

    // Collision on the SOF cycle belongs to the following frame.
    cp = 1'b1;
    do_sof(t);
    cp = 1'b0;
    push(OpMove, 4'b0, 1'b0, DIR_NONE, t + 2);
    tick(8);
    do_sof(t);
    push(OpPlat, 4'b0, 1'b0, DIR_NONE, t + 2);
    push(OpMove, 4'b0, 1'b0, DIR_NONE, t + 4);
    tick(8);

    // Direction: both keys -> left; right only -> right.
    nl = 1'b0; nr = 1'b0; tick(4);
    do_sof(t);
    push(OpMove, 4'b0, 1'b0, DIR_LEFT, t + 2);
    tick(8);
    nl = 1'b1; tick(4);
    do_sof(t);
    push(OpMove, 4'b0, 1'b0, DIR_RIGHT, t + 2);
    tick(8);
    nr = 1'b1; tick(4);

    // Jump pressed in frame 0, PLAT issued at SOF 3: jump still buffered, consumed once.
    nj = 1'b0; tick(3); nj = 1'b1; tick(3);
    repeat (2) begin
      do_sof(t); push(OpMove, 4'b0, 1'b0, DIR_NONE, t + 2); tick(6);
    end
    cp = 1'b1; ct = 1'b1; tick(1);
    cp = 1'b0; ct = 1'b0; tick(1);
    do_sof(t);
    push(OpPlat, 4'b0, 1'b1, DIR_NONE, t + 2);
    push(OpTrans, 4'b0, 1'b0, DIR_NONE, t + 4);
    push(OpMove, 4'b0, 1'b0, DIR_NONE, t + 6);
    tick(10);

    // Same press, PLAT issued at SOF 5: buffer expired at SOF 4.
    nj = 1'b0; tick(3); nj = 1'b1; tick(3);
    repeat (4) begin
      do_sof(t); push(OpMove, 4'b0, 1'b0, DIR_NONE, t + 2); tick(6);
    end
    cp = 1'b1; tick(1); cp = 1'b0; tick(1);
    do_sof(t);
    push(OpPlat, 4'b0, 1'b0, DIR_NONE, t + 2);
    push(OpMove, 4'b0, 1'b0, DIR_NONE, t + 4);
    tick(10);
    check("no_overrun_yet", 32'(overrun), 0);

    // Overrun: WALL never accepted, next SOF drops it and restarts from the new snapshot.
    cw = 1'b1; hec = e_bottom; tick(1);
    cw = 1'b0; hec = 4'b0; tick(1);
    rdy = 1'b0;
    do_sof(t);
    tick(3);
    cp = 1'b1; tick(1); cp = 1'b0;
    do_sof(t2);
    rdy = 1'b1;
    push(OpPlat, 4'b0, 1'b0, DIR_NONE, t2 + 2);
    push(OpMove, 4'b0, 1'b0, DIR_NONE, t2 + 4);
    tick(2);
    check("overrun_flag", 32'(overrun), 1);
    check("overrun_cnt", 32'(overrun_cnt), 32'(stat_exp(1)));
    check("frame_cnt_ovr", 32'(frame_cnt), 32'(stat_exp(exp_frames)));
    tick(8);
    check("overrun_sticky", 32'(overrun), 1);

    // Reset mid-ISSUE with a wall already accumulated for the next frame.
    rdy = 1'b0;
    do_sof(t);
    tick(1);
    cw = 1'b1; hec = 4'b1111; tick(1);
    cw = 1'b0; hec = 4'b0;
    reset = 1'b1; tick(3); reset = 1'b0;
    exp_frames = 0;
    check("rst2_valid", 32'(cmd_valid), 0);
    check("rst2_op", 32'(cmd_op), 0);
    check("rst2_overrun", 32'(overrun), 0);
    check("rst2_overrun_cnt", 32'(overrun_cnt), 0);
    check("rst2_frame_cnt", 32'(frame_cnt), 0);
    rdy = 1'b1; tick(2);
    do_sof(t);
    push(OpMove, 4'b0, 1'b0, DIR_NONE, t + 2);
    tick(8);

    // Frame counter saturates rather than wrapping.
    repeat (260) begin
      do_sof(t); push(OpMove, 4'b0, 1'b0, DIR_NONE, t + 2); tick(5);
    end
    check("frame_cnt_sat", 32'(frame_cnt), 32'(stat_exp(exp_frames)));
    check("overrun_clear", 32'(overrun), 0);

    for (int i = 0; i < 40 && q.size() != 0; i++) tick(1);
    check("drain", 32'(q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, bad);
    $finish;
  end

endmodule
